// File: rtl/cla_share_arb.sv
// Round-robin sequencer sharing one adder; result registered ADD_LAT+1 cycles after accept.
// No grant is made until the held response has been taken (resp_valid & resp_ready).
module cla_share_arb #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  input  logic [N_REQ-1:0]         req_cin,
  output logic [N_REQ-1:0]         req_ready,
  output logic [W-1:0]             add_a,
  output logic [W-1:0]             add_b,
  output logic                     add_cin,
  output logic                     add_en,
  input  logic [W-1:0]             add_sum,
  input  logic                     add_cout,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [W-1:0]             resp_sum,
  output logic                     resp_cout,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } opnd_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] ptr_nxt;
  logic           gnt_vld;
  logic [2:0]     lat_cnt;
  opnd_t          opnd_q;
  opnd_t          gnt_opnd;
  logic           accept;
  logic           capture;
  logic           lat_dec;
  logic           done;

  // Index k positions after base, wrapped into 0..N_REQ-1.
  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && req_valid[rot_idx(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rot_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    gnt_opnd.a   = req_a[int'(gnt_idx)*W +: W];
    gnt_opnd.b   = req_b[int'(gnt_idx)*W +: W];
    gnt_opnd.cin = req_cin[gnt_idx];
    ptr_nxt      = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // rst_n gates the grant so req_ready is quiet for the whole reset window.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    add_en    = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    lat_dec   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (gnt_vld && rst_n) begin
          req_ready = N_REQ'(1) << gnt_idx;
          accept    = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        add_en = 1'b1;
        if (lat_cnt == 3'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          lat_dec = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q     <= '0;
      rr_ptr     <= '0;
      lat_cnt    <= 3'd0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_id    <= '0;
    end else begin
      if (accept) begin
        opnd_q  <= gnt_opnd;
        resp_id <= gnt_idx;
        rr_ptr  <= ptr_nxt;
        lat_cnt <= 3'(ADD_LAT);
      end
      if (lat_dec) lat_cnt <= lat_cnt - 3'd1;
      if (capture) begin
        resp_sum   <= add_sum;
        resp_cout  <= add_cout;
        resp_valid <= 1'b1;
      end
      if (done) resp_valid <= 1'b0;
    end
  end

  assign add_a   = opnd_q.a;
  assign add_b   = opnd_q.b;
  assign add_cin = opnd_q.cin;

endmodule

// File: tb/tb_cla_share_arb.sv
// Bench for cla_share_arb: transaction-level model on a 1-cycle adder instance, directed timing on a 3-cycle one.
module tb_cla_share_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance with a one-cycle adder
  logic           rst_n;
  logic [N-1:0]   req_valid, req_cin, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_sum, resp_sum;
  logic           add_cin, add_en, add_cout, resp_valid, resp_ready, resp_cout, busy;
  logic [1:0]     resp_id;

  // instance with a three-cycle adder
  logic           rst3_n;
  logic [N-1:0]   req_valid3, req_cin3, req_ready3;
  logic [N*W-1:0] req_a3, req_b3;
  logic [W-1:0]   add_a3, add_b3, add_sum3, resp_sum3;
  logic           add_cin3, add_en3, add_cout3, resp_valid3, resp_ready3, resp_cout3, busy3;
  logic [1:0]     resp_id3;

  cla_share_arb #(.N_REQ(N), .W(W), .ADD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_en(add_en), .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
    .resp_cout(resp_cout), .resp_id(resp_id), .busy(busy)
  );

  cla_share_arb #(.N_REQ(N), .W(W), .ADD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_cin(req_cin3), .req_ready(req_ready3), .add_a(add_a3), .add_b(add_b3),
    .add_cin(add_cin3), .add_en(add_en3), .add_sum(add_sum3), .add_cout(add_cout3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_sum(resp_sum3),
    .resp_cout(resp_cout3), .resp_id(resp_id3), .busy(busy3)
  );

  // pipelined adders standing in for the shared clac
  logic [W:0] s1;
  logic [W:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    s1   <= add_a + add_b + add_cin;
    p3_0 <= add_a3 + add_b3 + add_cin3;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign {add_cout, add_sum}   = s1;
  assign {add_cout3, add_sum3} = p3_2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Transaction model: idle / waiting for the adder / holding a result.
  int         m_mode;
  int         m_edges;
  int         m_ptr;
  int         m_id;
  logic [W:0] m_res;
  logic [W-1:0] m_a, m_b;
  logic         m_c;

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_mode = 0;
      m_ptr  = 0;
    end else begin
      case (m_mode)
        0: begin
          g = pick(req_valid, m_ptr);
          if (g >= 0) begin
            m_a     = req_a[g*W +: W];
            m_b     = req_b[g*W +: W];
            m_c     = req_cin[g];
            m_res   = m_a + m_b + m_c;
            m_id    = g;
            m_ptr   = (g + 1) % N;
            m_edges = 1 + 1;
            m_mode  = 1;
          end
        end
        1: begin
          m_edges = m_edges - 1;
          if (m_edges == 0) m_mode = 2;
        end
        default: if (resp_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    int p;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_add_en", add_en, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp", {resp_cout, resp_sum, resp_id}, 0);
      chk("rst_add_ops", {add_a, add_b, add_cin}, 0);
    end else begin
      p = pick(req_valid, m_ptr);
      exp_rdy = (m_mode == 0 && p >= 0) ? (N'(1) << p) : '0;
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_busy", busy, m_mode != 0);
      chk("m_add_en", add_en, m_mode == 1);
      chk("m_resp_valid", resp_valid, m_mode == 2);
      if (m_mode != 0) chk("m_add_ops", {add_a, add_b, add_cin}, {m_a, m_b, m_c});
      if (m_mode == 2) begin
        chk("m_resp_sum", {resp_cout, resp_sum}, m_res);
        chk("m_resp_id", resp_id, m_id);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int c);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_cin[i]      = c[0];
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL grant_timeout: no req_ready in 30 cycles, required a grant");
  endtask

  task automatic wait_resp(output logic [W:0] tot, output int id);
    tot = '0;
    id  = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (resp_valid) begin
        tot = {resp_cout, resp_sum};
        id  = resp_id;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL resp_timeout: no resp_valid in 30 cycles, required a response");
  endtask

  task automatic do_txn(input int i, input int a, input int b, input int c, input int exp_tot,
                        input string nm);
    int g, id;
    logic [W:0] tot;
    set_req(i, a, b, c);
    wait_grant(g);
    chk({nm, "_gnt"}, g, i);
    step();
    req_valid[i] = 1'b0;
    wait_resp(tot, id);
    chk({nm, "_sum"}, tot, exp_tot);
    chk({nm, "_id"}, id, i);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, id, n;
    int ord[5];
    int expv[4];
    logic [W:0] tot;
    logic [N-1:0] acc;
    ord  = '{0, 1, 2, 3, 0};
    expv = '{12, 19, 151, 300};

    rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; req_cin = '0; resp_ready = 1'b1;
    rst3_n = 1'b0; req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_cin3 = '0; resp_ready3 = 1'b1;
    step(); step(); step();
    req_valid = '0;
    rst_n = 1'b1;
    rst3_n = 1'b1;
    step();

    // single request: accept at E0, response visible after E2
    set_req(0, 24, 1, 1);
    @(negedge clk); chk("single_ready", req_ready, 4'b0001);
    step(); req_valid[0] = 1'b0;
    @(negedge clk); chk("single_e0_busy", busy, 1);
    chk("single_e0_rv", resp_valid, 0);
    step();
    @(negedge clk); chk("single_e1_rv", resp_valid, 0);
    step();
    @(negedge clk); chk("single_e2_rv", resp_valid, 1);
    chk("single_sum", resp_sum, 26);
    chk("single_cout", resp_cout, 0);
    chk("single_id", resp_id, 0);
    step();
    @(negedge clk); chk("single_idle", busy, 0);
    step();

    // overflow
    do_txn(1, 255, 1, 0, 256, "ovf1");
    do_txn(2, 255, 255, 1, 511, "ovf2");

    // all requesters continuously valid from reset
    do_reset();
    set_req(0, 5, 7, 0);
    set_req(1, 9, 9, 1);
    set_req(2, 100, 50, 1);
    set_req(3, 200, 100, 0);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", g, ord[k]);
      step();
      wait_resp(tot, id);
      chk("rr_id", id, g);
      if (g >= 0) chk("rr_sum", tot, expv[g]);
      step();
    end
    req_valid = '0;

    // wrap: after grant to 2, requesters 1 and 3 -> 3 then 1
    do_txn(2, 3, 4, 0, 7, "wrap_pre");
    set_req(1, 10, 20, 0);
    set_req(3, 1, 1, 1);
    wait_grant(g); chk("wrap_first", g, 3);
    step(); req_valid[3] = 1'b0;
    wait_resp(tot, id); step();
    wait_grant(g); chk("wrap_second", g, 1);
    step(); req_valid[1] = 1'b0;
    wait_resp(tot, id); chk("wrap_sum", tot, 30);
    step();

    // backpressure in RESP
    resp_ready = 1'b0;
    set_req(0, 40, 2, 0);
    wait_grant(g); chk("bp_gnt", g, 0);
    step(); req_valid[0] = 1'b0;
    set_req(1, 1, 2, 0);
    wait_resp(tot, id);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rv", resp_valid, 1);
      chk("bp_sum", resp_sum, 42);
      chk("bp_id", resp_id, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      step();
      @(negedge clk);
    end
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_rel_rv", resp_valid, 0);
    chk("bp_rel_busy", busy, 0);
    chk("bp_rel_ready", req_ready, 4'b0010);
    step(); req_valid[1] = 1'b0;
    wait_resp(tot, id); chk("bp_next_sum", tot, 3);
    step();

    // randomized traffic with withdrawals, backpressure and occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0 || (acc[i] && $urandom_range(0, 1) == 0))
            set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
          else
            req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    req_valid = '0;
    resp_ready = 1'b1;
    step(); step();

    // three-cycle adder: accept at E0, response visible after E4
    req_a3[1*W +: W] = 8'd100; req_b3[1*W +: W] = 8'd27; req_cin3[1] = 1'b1; req_valid3[1] = 1'b1;
    @(negedge clk); chk("l3_ready", req_ready3, 4'b0010);
    step(); req_valid3 = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("l3_wait_rv", resp_valid3, 0);
      chk("l3_add_en", add_en3, 1);
      step();
    end
    @(negedge clk);
    chk("l3_rv", resp_valid3, 1);
    chk("l3_sum", {resp_cout3, resp_sum3}, 128);
    chk("l3_id", resp_id3, 1);
    step();

    // reset during CALC abandons the transaction
    req_a3[2*W +: W] = 8'd7; req_b3[2*W +: W] = 8'd8; req_cin3[2] = 1'b0; req_valid3[2] = 1'b1;
    @(negedge clk); chk("l3r_ready", req_ready3, 4'b0100);
    step(); req_valid3 = '0;
    step();
    rst3_n = 1'b0;
    #1;
    chk("l3r_busy", busy3, 0);
    chk("l3r_add_en", add_en3, 0);
    chk("l3r_rv", resp_valid3, 0);
    chk("l3r_ops", {add_a3, add_b3, add_cin3}, 0);
    chk("l3r_resp", {resp_cout3, resp_sum3, resp_id3}, 0);
    chk("l3r_ready0", req_ready3, 0);
    step();
    rst3_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("l3r_quiet_rv", resp_valid3, 0);
      chk("l3r_quiet_busy", busy3, 0);
    end
    step();
    req_a3[0 +: W] = 8'd1; req_b3[0 +: W] = 8'd2; req_cin3[0] = 1'b0; req_valid3[0] = 1'b1;
    @(negedge clk); chk("l3n_ready", req_ready3, 4'b0001);
    step(); req_valid3 = '0;
    n = 0;
    for (int t = 1; t <= 10 && n == 0; t++) begin
      @(negedge clk);
      if (resp_valid3) n = t;
    end
    chk("l3n_latency", n, 5);
    chk("l3n_sum", {resp_cout3, resp_sum3}, 3);
    chk("l3n_id", resp_id3, 0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
